// File: rtl/fifo_reader.sv
// Read-side master for an 8-bit synchronous FIFO: issues read strobes, captures the
// returned word into a 2-entry skid buffer and presents it on a valid/ready stream.
// Optional macro FIFO_READER_COUNT_EN adds a 16-bit wrapping count of delivered words.
module fifo_reader #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_read_n,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [15:0]       rd_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        occ_q, occ_d;
  logic              in_flight_q, in_flight_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  logic              pop;
  logic [2:0]        pending;
  logic              read_ok;

  assign pop = m_valid_q & m_ready;

  // Words that will occupy the buffer after this edge if no new read is issued.
  assign pending = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
  assign read_ok = reset & (state_q == ST_RUN) & enable & ~fifo_empty & (pending < 3'd2);

  assign fifo_read_n = ~read_ok;
  assign in_flight_d = read_ok;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({in_flight_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = fifo_data;
        else               tail_d = fifo_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = fifo_data;
        end else begin
          head_d = fifo_data;
        end
      end
      default: ;
    endcase
    m_valid_d = (occ_d != 2'd0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_d = ((occ_q != 2'd0) || in_flight_q) ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        if (enable)                                  state_d = ST_RUN;
        else if ((occ_q == 2'd0) && !in_flight_q)    state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      occ_q       <= 2'd0;
      in_flight_q <= 1'b0;
      m_valid_q   <= 1'b0;
      // NOTE: the two buffer entries are reset as well, since the head drives m_data
      // and must read 0 out of reset.
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      in_flight_q <= in_flight_d;
      m_valid_q   <= m_valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = head_q;
  assign busy    = (state_q != ST_IDLE);

`ifdef FIFO_READER_COUNT_EN
  logic [15:0] rd_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   rd_count_q <= 16'h0000;
    else if (pop) rd_count_q <= rd_count_q + 16'h0001;
  end

  assign rd_count = rd_count_q;
`endif

endmodule
